// File: rtl/usr_pkg.sv
// usr_pkg: shared mode encodings for the universal shift register.
package usr_pkg;
    typedef enum logic [1:0] {
        HOLD = 2'b00,
        SHR  = 2'b01,
        SHL  = 2'b10,
        LOAD = 2'b11
    } mode_e;
endpackage

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: hold/shift-right/shift-left/load register with word-shift counter and done pulse.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic [WIDTH-1:0]         d,
    input  logic                     ser_msb,
    input  logic                     ser_lsb,
    output logic [WIDTH-1:0]         q,
    output logic                     sout_lsb,
    output logic                     sout_msb,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     done
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             shift;
    always_comb begin
        shift  = en && (mode == SHR || mode == SHL);
        q_d    = !en            ? q_q
               : mode == SHR    ? {ser_msb, q_q[WIDTH-1:1]}
               : mode == SHL    ? {q_q[WIDTH-2:0], ser_lsb}
               : mode == LOAD   ? d
               : q_q;
        // a load aborts the current word, so the count restarts
        cnt_d  = (en && mode == LOAD) ? '0
               : !shift               ? cnt_q
               : cnt_q == LAST        ? '0
               : cnt_q + CW'(1);
        done_d = shift && cnt_q == LAST;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= RST_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end
    assign q        = q_q;
    assign cnt      = cnt_q;
    assign done     = done_q;
    assign sout_lsb = q_q[0];
    assign sout_msb = q_q[WIDTH-1];
endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 SHALL have parameter RST_VAL, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  operation enable; 0 = hold all state.
REQ-006 SHALL have port mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 SHALL have port d  input  WIDTH  parallel load data.
REQ-008 SHALL have port ser_msb  input  1  serial bit entering q[WIDTH-1] on shift right.
REQ-009 SHALL have port ser_lsb  input  1  serial bit entering q[0] on shift left.
REQ-010 SHALL have port q  output  WIDTH  register contents.
REQ-011 SHALL have port sout_lsb  output  1  combinational copy of q[0].
REQ-012 SHALL have port sout_msb  output  1  combinational copy of q[WIDTH-1].
REQ-013 SHALL have port cnt  output  $clog2(WIDTH)  number of shifts since the last load, reset or word completion.
REQ-014 SHALL have port done  output  1  registered one-cycle pulse marking a full word shifted.

Function
REQ-015 With en=1, mode=00: q and cnt SHALL hold; done SHALL be 0 on the next cycle.
REQ-016 With en=1, mode=01: q SHALL become {ser_msb, q[WIDTH-1:1]} at the next edge.
REQ-017 With en=1, mode=10: q SHALL become {q[WIDTH-2:0], ser_lsb} at the next edge.
REQ-018 With en=1, mode=11: q SHALL become d at the next edge (latency 1); cnt SHALL clear to 0; done SHALL be 0.
REQ-019 Each shift (mode 01 or 10, en=1) SHALL increment cnt by 1.
REQ-020 On a shift with cnt==WIDTH-1: cnt SHALL wrap to 0 and done SHALL be 1 for exactly the following cycle.
REQ-021 done SHALL be 0 in every cycle not covered by REQ-020.
REQ-022 Mixed left/right shifts SHALL count identically; direction changes SHALL not clear cnt.
REQ-023 With en=0: q and cnt SHALL hold regardless of mode; done SHALL be 0 on the next cycle.
REQ-024 Load issued mid-word SHALL discard the partial count; no done SHALL be produced for the aborted word.
REQ-025 sout_lsb and sout_msb SHALL track q with zero latency; they SHALL have no registered copies.

Reset
REQ-026 rst=1 at a rising edge SHALL set q=RST_VAL, cnt=0, done=0, overriding en, mode and all data inputs.
REQ-027 Reset asserted mid-word SHALL abort the word with no done pulse; the first shift after reset SHALL count as shift 1.
REQ-028 With rst=0, outputs SHALL not change except at a rising clk edge.

Structure
REQ-029 Mode encodings (HOLD, SHR, SHL, LOAD) SHALL be defined as named constants in shared package usr_pkg and referenced from there.
REQ-030 The block SHALL be implemented as a single module; no sub-module is required; the counter and data register SHALL share one clocked process.

Verification (WIDTH=8, RST_VAL=0 unless stated)
REQ-031 Test: q=0xA5, cnt=3, rst=1 with en=1, mode=11, d=0xFF -> after the edge q=0x00, cnt=0, done=0 (reset wins).
REQ-032 Test: load d=0x3C, then 8 shift-left edges with ser_lsb=1 -> q=0xFF after the 8th edge, cnt=0, done=1 for that one cycle only.
REQ-033 Test: load 0x81, one shift right with ser_msb=0 -> q=0x40, sout_lsb=0, sout_msb=0, cnt=1.
REQ-034 Test: after 5 shifts, en=0 with mode=01 for 3 cycles -> q and cnt=5 unchanged, done=0; then 3 shifts -> done pulses after the 8th counted shift.
REQ-035 Test: after 5 shifts, load 0x11 -> cnt=0; 7 further shifts -> no done; 8th further shift -> done=1.
REQ-036 Test: RST_VAL=0x5A, rst=1 at cnt=7 -> q=0x5A, cnt=0, no done pulse in the following cycle.
